// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Brief    : Shared constants and types for the single-cycle RISC-V core:
//             opcodes, BrOp encodings, branch F3 codes, fetch FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // BrOp[4:3] class; BrOp[4]=1 alone marks an unconditional jump
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic       BR_JUMP = 1'b1;

  // Branch conditions carried in BrOp[2:0] (same as branch F3)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : branch_cmp
//  Brief    : Combinational branch/jump decision from BrOp and the two
//             register-file operands.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_cmp
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      BrOp,
  output logic            taken
);

  logic w_cond;

  // Evaluate the condition selected by BrOp[2:0]; codes 010/011 never take
  always_comb begin
    w_cond = 1'b0;
    case (BrOp[2:0])
      F3_BEQ:  w_cond = (rs1_data == rs2_data);
      F3_BNE:  w_cond = (rs1_data != rs2_data);
      F3_BLT:  w_cond = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  w_cond = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: w_cond = (rs1_data <  rs2_data);
      F3_BGEU: w_cond = (rs1_data >= rs2_data);
      default: w_cond = 1'b0;
    endcase
    taken = (BrOp[4] == BR_JUMP) || ((BrOp[4:3] == BR_COND) && w_cond);
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction fetch and next-PC stage. Owns the PC, fetches over a
//             req/gnt + rvalid handshake, holds the instruction during EXEC
//             and resolves branches/jumps into the next PC.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [6:0]      OpCode,
  output logic [2:0]      F3,
  output logic [6:0]      F7,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic [4:0]      BrOp,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] alu_res,
  input  logic            stall,
  output logic            misalign_err
);

  fetch_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_misalign;

  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_pc_load;
  logic            w_instr_load;
  logic            w_set_misalign;

  branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .BrOp     (BrOp),
    .taken    (w_taken)
  );

  // Jump target always has bit 0 cleared; bit 1 set means a misaligned target
  assign w_target = alu_res & ~{{(XLEN-1){1'b0}}, 1'b1};
  assign pc_plus4 = r_pc + XLEN'(4);
  assign w_pc_nxt = w_taken ? w_target : pc_plus4;

  // Output view of the registered state
  assign pc           = r_pc;
  assign imem_addr    = r_pc;
  assign instr        = r_instr;
  assign OpCode       = r_instr[6:0];
  assign F3           = r_instr[14:12];
  assign F7           = r_instr[31:25];
  assign misalign_err = r_misalign;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next-state, handshake outputs and register load enables
  always_comb begin
    w_state_nxt    = r_state;
    imem_req       = 1'b0;
    instr_valid    = 1'b0;
    w_pc_load      = 1'b0;
    w_instr_load   = 1'b0;
    w_set_misalign = 1'b0;
    case (r_state)
      FETCH: begin
        // Request is masked while reset is held so nothing leaks to memory
        imem_req = rst_n;
        if (imem_gnt) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_instr_load = 1'b1;
          w_state_nxt  = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          if (w_taken && w_target[1]) begin
            w_set_misalign = 1'b1;
            w_state_nxt    = HALT;
          end else begin
            w_pc_load   = 1'b1;
            w_state_nxt = FETCH;
          end
        end
      end
      HALT: w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  // PC, instruction latch and sticky misalignment flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_pc_load)      r_pc       <= w_pc_nxt;
      if (w_instr_load)   r_instr    <= imem_rdata;
      if (w_set_misalign) r_misalign <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Self-checking bench for fetch_unit: directed scenarios followed
//             by randomized instructions against a PC-sequence model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [6:0]  OpCode;
  logic [2:0]  F3;
  logic [6:0]  F7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [4:0]  BrOp;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] alu_res;
  logic        stall;
  logic        misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .OpCode       (OpCode),
    .F3           (F3),
    .F7           (F7),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .BrOp         (BrOp),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .alu_res      (alu_res),
    .stall        (stall),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Branch rule straight from the ISA semantics of BrOp
  function automatic bit ref_taken(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[4]) return 1'b1;
    if (!op[3]) return 1'b0;
    case (op[2:0])
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // One complete instruction: fetch with gd grant-wait cycles, rd response-wait
  // cycles, st stall cycles in EXEC. Returns 1 when the model expects HALT.
  task automatic do_instr(input logic [31:0] word, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] alu, input int gd, input int rd,
                          input int st, output bit halted);
    logic [31:0] tgt;
    logic [31:0] nxt;
    logic [31:0] junk;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
    bit          tk;
    e_op = word[6:0];
    e_f3 = word[14:12];
    e_f7 = word[31:25];
    halted = 1'b0;
    // FETCH with grant withheld
    for (int i = 0; i < gd; i++) begin
      imem_gnt = 1'b0;
      chk("fetch_req_hold", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr_hold", imem_addr, m_pc);
      tick;
    end
    imem_gnt = 1'b1;
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
    tick;
    imem_gnt = 1'b0;
    // WAIT for the response
    for (int i = 0; i < rd; i++) begin
      junk = $urandom;
      imem_rdata = junk;
      imem_rvalid = 1'b0;
      chk("wait_req", {31'd0, imem_req}, 32'd0);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      tick;
    end
    imem_rdata  = word;
    imem_rvalid = 1'b1;
    chk("wait_req_last", {31'd0, imem_req}, 32'd0);
    tick;
    imem_rvalid = 1'b0;
    // EXEC
    BrOp = op; rs1_data = a; rs2_data = b; alu_res = alu;
    for (int i = 0; i <= st; i++) begin
      stall = (i < st);
      if (i < st) begin
        // Stray responses outside WAIT must not disturb the held instruction
        junk = $urandom;
        imem_rdata  = junk;
        imem_rvalid = junk[0];
      end
      chk("exec_valid", {31'd0, instr_valid}, 32'd1);
      chk("exec_instr", instr, word);
      chk("exec_opcode", {25'd0, OpCode}, {25'd0, e_op});
      chk("exec_f3", {29'd0, F3}, {29'd0, e_f3});
      chk("exec_f7", {25'd0, F7}, {25'd0, e_f7});
      chk("exec_pc", pc, m_pc);
      chk("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("exec_req", {31'd0, imem_req}, 32'd0);
      tick;
      imem_rvalid = 1'b0;
    end
    stall = 1'b0;
    tk  = ref_taken(op, a, b);
    tgt = {alu[31:1], 1'b0};
    nxt = tk ? tgt : m_pc + 32'd4;
    if (tk && tgt[1]) begin
      halted = 1'b1;
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_misalign", {31'd0, misalign_err}, 32'd1);
      chk("halt_pc", pc, m_pc);
    end else begin
      m_pc = nxt;
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", imem_addr, m_pc);
      chk("next_misalign", {31'd0, misalign_err}, 32'd0);
    end
  endtask

  initial begin
    bit          h;
    logic [31:0] r, a, b, alu, w;
    logic [4:0]  op;
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    BrOp = '0; rs1_data = '0; rs2_data = '0; alu_res = '0; stall = 1'b0;
    m_pc = 32'h0;
    tick; tick;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    // Reset asserted while in WAIT
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("midwait_pc", pc, 32'h0);
    chk("midwait_req", {31'd0, imem_req}, 32'd0);
    chk("midwait_valid", {31'd0, instr_valid}, 32'd0);
    chk("midwait_misalign", {31'd0, misalign_err}, 32'd0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("midwait_rel_req", {31'd0, imem_req}, 32'd1);
    chk("midwait_rel_addr", imem_addr, 32'h0);

    // Directed flow
    do_instr(32'h002081B3, 5'b00000, 32'd0, 32'd0, 32'h0, 0, 0, 0, h);     // -> 0x4
    do_instr(32'h00000013, 5'b00000, 32'd0, 32'd0, 32'h0, 2, 1, 0, h);     // -> 0x8
    do_instr(32'h04208063, 5'b01000, 32'd5, 32'd5, 32'h40, 0, 0, 3, h);    // BEQ taken -> 0x40
    do_instr(32'h04209063, 5'b01001, 32'd5, 32'd5, 32'h80, 0, 0, 0, h);    // BNE not taken -> 0x44
    do_instr(32'h0020C063, 5'b01100, 32'hFFFF_FFFF, 32'd1, 32'h80, 0, 0, 0, h); // BLT taken -> 0x80
    do_instr(32'h0020E063, 5'b01110, 32'hFFFF_FFFF, 32'd1, 32'h200, 0, 0, 0, h); // BLTU not -> 0x84
    do_instr(32'h000000E7, 5'b01010, 32'd3, 32'd3, 32'h300, 0, 0, 0, h);   // code 010 never -> 0x88
    do_instr(32'h000000E7, 5'b10000, 32'd0, 32'd0, 32'h101, 0, 2, 1, h);   // JALR -> 0x100
    do_instr(32'h0000006F, 5'b11111, 32'd0, 32'd0, 32'hFFFF_FFFC, 1, 0, 0, h); // -> 0xFFFFFFFC
    do_instr(32'h00000013, 5'b00111, 32'd1, 32'd1, 32'h0, 0, 0, 0, h);     // pc+4 wraps -> 0x0

    // Randomized instructions with word-aligned targets
    for (int k = 0; k < 40; k++) begin
      r  = $urandom;
      op = r[4:0];
      a  = $urandom;
      b  = (r[6:5] == 2'b00) ? a : $urandom;
      if (r[7]) b = ~a;
      alu = $urandom;
      alu = {alu[31:2], 1'b0, alu[0]};
      w  = $urandom;
      do_instr(w, op, a, b, alu, int'(r[9:8]), int'(r[11:10]), int'(r[13:12]), h);
    end

    // Misaligned jump target halts the core
    do_instr(32'h000000E7, 5'b10000, 32'd0, 32'd0, m_pc + 32'h102 - (m_pc & 32'h3), 0, 0, 0, h);
    chk("misalign_halted", {31'd0, h}, 32'd1);
    r = m_pc;
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      imem_gnt = w[0]; imem_rvalid = w[1]; imem_rdata = w;
      tick;
      chk("halt_hold_req", {31'd0, imem_req}, 32'd0);
      chk("halt_hold_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_hold_misalign", {31'd0, misalign_err}, 32'd1);
      chk("halt_hold_pc", pc, r);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("final_rst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("final_rst_pc", pc, 32'h0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("final_rel_addr", imem_addr, 32'h0);
    chk("final_rel_req", {31'd0, imem_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and next-PC stage of the single-cycle RISC-V core.
- Owns the PC register and fetches each instruction from instruction memory over a request/response handshake.
- Holds the fetched word and presents its OpCode/F3/F7 fields to the control unit.
- Consumes the control unit's BrOp, the register-file operands and the ALU result to resolve branches and jumps, then selects the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, data and address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous assert, active-low
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address; always equals pc
imem_gnt  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  instruction word
instr  out  32  latched instruction
instr_valid  out  1  instr is valid and executing
OpCode  out  7  instr[6:0]
F3  out  3  instr[14:12]
F7  out  7  instr[31:25]
pc  out  XLEN  current PC
pc_plus4  out  XLEN  pc + 4, used for JAL/JALR writeback
BrOp  in  5  branch operation from the control unit
rs1_data  in  XLEN  register-file operand A
rs2_data  in  XLEN  register-file operand B
alu_res  in  XLEN  ALU result; branch/jump target
stall  in  1  hold current instruction in EXEC (e.g. data-memory wait)
misalign_err  out  1  sticky: taken target not word-aligned

Behaviour:
- Reset:
  - rst_n low asynchronously forces state=FETCH and pc=RESET_PC.
  - instr=0, instr_valid=0, misalign_err=0.
  - imem_req is 0 while rst_n is low.
  - Instruction memory shares rst_n; any outstanding response is discarded.
- States: FETCH, WAIT, EXEC, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> WAIT. Otherwise req and addr stay stable.
- WAIT:
  - imem_req=0; at most one request outstanding.
  - imem_rvalid=1 -> latch imem_rdata into instr -> EXEC.
  - imem_rvalid is never asserted in the same cycle as imem_gnt. imem_rvalid outside WAIT is ignored.
- EXEC:
  - instr_valid=1; OpCode/F3/F7 are sliced from the registered instr.
  - stall=1 -> hold pc, instr and state.
  - stall=0 -> resolve next PC, load pc, go to FETCH.
- Branch resolution (combinational, in EXEC):
  - BrOp[4]=1: taken (JAL/JALR).
  - BrOp[4:3]=00: not taken; BrOp[2:0] is don't-care.
  - BrOp[4:3]=01: conditional on BrOp[2:0]:
    - 000 eq; 001 ne.
    - 100 signed lt; 101 signed ge.
    - 110 unsigned lt; 111 unsigned ge.
    - 010 and 011: not taken.
- Next PC:
  - target = {alu_res[XLEN-1:1], 1'b0}, i.e. bit 0 is cleared (JALR rule).
  - next = taken ? target : pc+4.
  - pc_plus4 = pc+4, modulo 2^XLEN; wraps from 0xFFFF_FFFC to 0.
- Misalignment:
  - taken && target[1]=1 -> pc unchanged, misalign_err<=1, go to HALT.
  - Not-taken paths never misalign.
- HALT:
  - imem_req=0, instr_valid=0. misalign_err is held.
  - Exit only via rst_n.
- Latency:
  - Minimum 3 cycles per instruction: FETCH + WAIT + EXEC, with same-cycle gnt and rvalid on the next cycle.
  - Each extra gnt or rvalid wait cycle adds one cycle.
- Reset mid-WAIT or mid-EXEC returns to FETCH at RESET_PC on the next clock after release; no PC update occurs.
- Architectural state update:
  - The control unit, register file and data memory must gate writes with instr_valid.
  - EXEC is the only state where an instruction's side effects occur. Side effects occur once per EXEC exit; while stalled, writes must be qualified externally.

Decomposition:
- riscv_pkg holds:
  - opcode constants;
  - BrOp encodings (BR_NONE=2'b00, BR_COND=2'b01, BR_JUMP=1'b1 prefix);
  - branch F3 codes;
  - fetch_state_t enum {FETCH, WAIT, EXEC, HALT};
  - XLEN default.
- One combinational sub-module, branch_cmp: inputs rs1_data, rs2_data, BrOp; output taken.

Test Plan:
- Reset with rst_n low mid-WAIT -> pc=0, imem_req=0, instr_valid=0, misalign_err=0; after release imem_req=1, imem_addr=0x0.
- Sequential flow: imem_rdata=32'h002081B3, BrOp=5'b00000, gnt same cycle, rvalid next cycle:
  - OpCode=7'b0110011, F3=3'b000, F7=7'b0000000, instr_valid for 1 cycle.
  - Next imem_addr=0x4, 3 cycles later.
- BEQ at pc=0x8: rs1=rs2=5, BrOp=5'b01000, alu_res=0x40 -> next addr 0x40. Same with BrOp=5'b01001 -> next addr 0xC.
- Signed vs unsigned: rs1=0xFFFF_FFFF, rs2=1:
  - BrOp=5'b01100 -> taken.
  - BrOp=5'b01110 -> not taken, next addr pc+4.
- JALR: BrOp=5'b10000, alu_res=0x101 -> next addr 0x100. alu_res=0x102 -> misalign_err=1, state HALT, imem_req stays 0, pc unchanged.
- Stall and grant delay:
  - stall=1 for 3 cycles in EXEC -> pc and instr stable, instr_valid=1 throughout.
  - imem_gnt low for 2 cycles in FETCH -> imem_req=1 and imem_addr stable.
